// File: rtl/frame_mem_arbiter_if.sv
// Bus bundle between the frame BRAM arbiter and its surroundings: the write requester,
// the read requester and the single-port frame BRAM.
// slave  : arbiter side (takes requests and BRAM read data, drives acks and BRAM controls)
// master : surroundings side (requesters plus the BRAM itself)
interface frame_mem_arbiter_if #(
   parameter int N = 17,
   parameter int D = 16
);
   logic         wr_req;
   logic [N-1:0] wr_addr;
   logic [D-1:0] wr_data;
   logic         wr_ack;
   logic         rd_req;
   logic [N-1:0] rd_addr;
   logic         rd_ack;
   logic         rd_valid;
   logic [D-1:0] rd_data;
   logic         addr_err;
   logic         frame_done;
   logic         mem_ena;
   logic         mem_wea;
   logic [N-1:0] mem_addr;
   logic [D-1:0] mem_dina;
   logic [D-1:0] mem_douta;

   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_douta,
      output wr_ack, rd_ack, rd_valid, rd_data, addr_err, frame_done,
             mem_ena, mem_wea, mem_addr, mem_dina
   );

   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_douta,
      input  wr_ack, rd_ack, rd_valid, rd_data, addr_err, frame_done,
             mem_ena, mem_wea, mem_addr, mem_dina
   );
endinterface

// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: shares one single-port frame BRAM between a pixel-fill writer and a
// window-fetch reader. One access per cycle, all outputs registered (no combinational
// path from any request to the BRAM controls), in-order read return with a valid strobe,
// out-of-frame addresses acked with addr_err but never sent to the memory, and a
// frame_done pulse on the write of the last frame word.
// Build option: define ARB_ROUND_ROBIN_EN to resolve simultaneous requests round-robin;
// left undefined, the writer always wins a tie.
module frame_mem_arbiter #(
   parameter int N      = 17,
   parameter int D      = 16,
   parameter int WORDS  = 16384,
   parameter int RD_LAT = 1
) (
   input logic                clk,
   input logic                reset,
   frame_mem_arbiter_if.slave bus
);

   localparam logic [N-1:0] LAST_ADDR = N'(WORDS - 1);

   logic         wr_ack_reg;
   logic         rd_ack_reg;
   logic         rd_valid_reg;
   logic [D-1:0] rd_data_reg;
   logic         addr_err_reg;
   logic         frame_done_reg;
   logic         mem_ena_reg;
   logic         mem_wea_reg;
   logic [N-1:0] mem_addr_reg;
   logic [D-1:0] mem_dina_reg;

   // Read tags: stage 0 is the grant cycle, stage RD_LAT is the cycle mem_douta is valid.
   logic [RD_LAT:0] tag_valid_reg;
   logic [RD_LAT:0] tag_err_reg;

   logic wr_elig;
   logic rd_elig;
   logic wr_err;
   logic rd_err;
   logic wr_wins;
   logic grant_wr;
   logic grant_rd;

   // A requester acked this cycle still shows its old req, so it sits this round out.
   assign wr_elig = bus.wr_req && !wr_ack_reg;
   assign rd_elig = bus.rd_req && !rd_ack_reg;
   assign wr_err  = bus.wr_addr > LAST_ADDR;
   assign rd_err  = bus.rd_addr > LAST_ADDR;

`ifdef ARB_ROUND_ROBIN_EN
   // High when the writer has priority on the next tie (it was not granted last).
   logic wr_turn_reg;

   assign wr_wins = wr_turn_reg;

   // Round-robin pointer: flips toward the other requester after every grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_turn_reg <= 1'b1;
      end else if (grant_wr) begin
         wr_turn_reg <= 1'b0;
      end else if (grant_rd) begin
         wr_turn_reg <= 1'b1;
      end
   end
`else
   assign wr_wins = 1'b1;
`endif

   assign grant_wr = wr_elig && (!rd_elig || wr_wins);
   assign grant_rd = rd_elig && !grant_wr;

   // Register the grant decision: acks, error and frame-end flags for the grant cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ack_reg     <= 1'b0;
         rd_ack_reg     <= 1'b0;
         addr_err_reg   <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         wr_ack_reg     <= grant_wr;
         rd_ack_reg     <= grant_rd;
         addr_err_reg   <= (grant_wr && wr_err) || (grant_rd && rd_err);
         frame_done_reg <= grant_wr && (bus.wr_addr == LAST_ADDR);
      end
   end

   // Drive the BRAM for legal grants only; address/data hold their last value otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_ena_reg  <= 1'b0;
         mem_wea_reg  <= 1'b0;
         mem_addr_reg <= '0;
         mem_dina_reg <= '0;
      end else begin
         mem_ena_reg <= (grant_wr && !wr_err) || (grant_rd && !rd_err);
         mem_wea_reg <= grant_wr && !wr_err;
         if (grant_wr && !wr_err) begin
            mem_addr_reg <= bus.wr_addr;
            mem_dina_reg <= bus.wr_data;
         end else if (grant_rd && !rd_err) begin
            mem_addr_reg <= bus.rd_addr;
         end
      end
   end

   // Shift read tags alongside the BRAM latency; reset flushes reads in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_valid_reg <= '0;
         tag_err_reg   <= '0;
      end else begin
         tag_valid_reg <= {tag_valid_reg[RD_LAT-1:0], grant_rd};
         tag_err_reg   <= {tag_err_reg[RD_LAT-1:0], grant_rd && rd_err};
      end
   end

   // Capture returned read data; rejected reads return zero instead of BRAM output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
      end else begin
         rd_valid_reg <= tag_valid_reg[RD_LAT];
         if (tag_valid_reg[RD_LAT]) begin
            rd_data_reg <= tag_err_reg[RD_LAT] ? '0 : bus.mem_douta;
         end
      end
   end

   assign bus.wr_ack     = wr_ack_reg;
   assign bus.rd_ack     = rd_ack_reg;
   assign bus.rd_valid   = rd_valid_reg;
   assign bus.rd_data    = rd_data_reg;
   assign bus.addr_err   = addr_err_reg;
   assign bus.frame_done = frame_done_reg;
   assign bus.mem_ena    = mem_ena_reg;
   assign bus.mem_wea    = mem_wea_reg;
   assign bus.mem_addr   = mem_addr_reg;
   assign bus.mem_dina   = mem_dina_reg;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed testbench for frame_mem_arbiter: one instance with RD_LAT=1 carries most
// scenarios, a second with RD_LAT=2 checks the longer read return. Each has its own
// behavioural BRAM. Status vector layout used below:
// {wr_ack, rd_ack, rd_valid, addr_err, frame_done, mem_ena, mem_wea}
module tb_frame_mem_arbiter;
   localparam int N = 17;
   localparam int D = 16;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   frame_mem_arbiter_if #(.N(N), .D(D)) bus ();
   frame_mem_arbiter_if #(.N(N), .D(D)) bus2 ();

   frame_mem_arbiter #(.N(N), .D(D), .WORDS(16384), .RD_LAT(1)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   frame_mem_arbiter #(.N(N), .D(D), .WORDS(16384), .RD_LAT(2)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2)
   );

   // Behavioural BRAMs: latency 1 and latency 2.
   logic [D-1:0] ram1 [0:16383];
   logic [D-1:0] ram2 [0:16383];
   logic [D-1:0] q1 = '0;
   logic [D-1:0] q2a = '0;
   logic [D-1:0] q2b = '0;

   always @(posedge clk) begin
      if (bus.mem_ena) begin
         if (bus.mem_wea) ram1[bus.mem_addr[13:0]] <= bus.mem_dina;
         else             q1 <= ram1[bus.mem_addr[13:0]];
      end
   end
   always @(posedge clk) begin
      if (bus2.mem_ena) begin
         if (bus2.mem_wea) ram2[bus2.mem_addr[13:0]] <= bus2.mem_dina;
         else              q2a <= ram2[bus2.mem_addr[13:0]];
      end
      q2b <= q2a;
   end
   assign bus.mem_douta  = q1;
   assign bus2.mem_douta = q2b;

   function automatic logic [6:0] st1();
      return {bus.wr_ack, bus.rd_ack, bus.rd_valid, bus.addr_err, bus.frame_done,
              bus.mem_ena, bus.mem_wea};
   endfunction

   function automatic logic [6:0] st2();
      return {bus2.wr_ack, bus2.rd_ack, bus2.rd_valid, bus2.addr_err, bus2.frame_done,
              bus2.mem_ena, bus2.mem_wea};
   endfunction

   // Raise a write request after a clock edge and step to the negedge of its grant cycle.
   task automatic wr_to_grant(input logic [N-1:0] a, input logic [D-1:0] d);
      @(posedge clk); #1;
      bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic rd_to_grant(input logic [N-1:0] a);
      @(posedge clk); #1;
      bus.rd_req = 1'b1; bus.rd_addr = a;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      checks++;
      if (st1() !== 7'b0) $display("FAIL reset_flags got %b exp %b", st1(), 7'b0);
      else passes++;
      checks++;
      if ({bus.mem_addr, bus.mem_dina, bus.rd_data} !== 49'b0)
         $display("FAIL reset_buses got %h exp 0", {bus.mem_addr, bus.mem_dina, bus.rd_data});
      else passes++;
      reset = 1'b1;
   endtask

   task automatic test_write_basic();
      @(posedge clk); #1;
      bus.wr_req = 1'b1; bus.wr_addr = 17'h00005; bus.wr_data = 16'hBEEF;
      @(negedge clk);
      checks++;
      if (st1() !== 7'b0) $display("FAIL wr_same_cycle got %b exp %b", st1(), 7'b0);
      else passes++;
      @(posedge clk); @(negedge clk);
      checks++;
      if (st1() !== 7'b1000011) $display("FAIL wr_grant got %b exp %b", st1(), 7'b1000011);
      else passes++;
      checks++;
      if ({bus.mem_addr, bus.mem_dina} !== {17'h00005, 16'hBEEF})
         $display("FAIL wr_bus got %h/%h exp 00005/beef", bus.mem_addr, bus.mem_dina);
      else passes++;
      bus.wr_req = 1'b0;
      @(negedge clk);
      checks++;
      if (st1() !== 7'b0 || bus.mem_addr !== 17'h00005)
         $display("FAIL wr_after got %b addr %h exp 0000000 addr 00005", st1(), bus.mem_addr);
      else passes++;
   endtask

   task automatic test_read_latency();
      rd_to_grant(17'h00005);
      checks++;
      if (st1() !== 7'b0100010 || bus.mem_addr !== 17'h00005)
         $display("FAIL rd_grant got %b addr %h exp 0100010 addr 00005", st1(), bus.mem_addr);
      else passes++;
      bus.rd_req = 1'b0;
      @(negedge clk);
      checks++;
      if (st1() !== 7'b0) $display("FAIL rd_c1 got %b exp %b", st1(), 7'b0);
      else passes++;
      @(negedge clk);
      checks++;
      if (st1() !== 7'b0010000 || bus.rd_data !== 16'hBEEF)
         $display("FAIL rd_c2 got %b data %h exp 0010000 data beef", st1(), bus.rd_data);
      else passes++;
      @(negedge clk);
      checks++;
      if (st1() !== 7'b0) $display("FAIL rd_c3 got %b exp %b", st1(), 7'b0);
      else passes++;

      // Second instance, BRAM latency 2: write then read back one cycle later than above.
      @(posedge clk); #1;
      bus2.wr_req = 1'b1; bus2.wr_addr = 17'h00005; bus2.wr_data = 16'h1234;
      @(posedge clk); @(negedge clk);
      checks++;
      if (st2() !== 7'b1000011) $display("FAIL lat2_wr got %b exp %b", st2(), 7'b1000011);
      else passes++;
      bus2.wr_req = 1'b0;
      @(posedge clk); #1;
      bus2.rd_req = 1'b1; bus2.rd_addr = 17'h00005;
      @(posedge clk); @(negedge clk);
      checks++;
      if (st2() !== 7'b0100010) $display("FAIL lat2_rd_grant got %b exp %b", st2(), 7'b0100010);
      else passes++;
      bus2.rd_req = 1'b0;
      @(negedge clk); @(negedge clk);
      checks++;
      if (st2() !== 7'b0) $display("FAIL lat2_c2 got %b exp %b", st2(), 7'b0);
      else passes++;
      @(negedge clk);
      checks++;
      if (st2() !== 7'b0010000 || bus2.rd_data !== 16'h1234)
         $display("FAIL lat2_c3 got %b data %h exp 0010000 data 1234", st2(), bus2.rd_data);
      else passes++;
      @(negedge clk);
      checks++;
      if (st2() !== 7'b0) $display("FAIL lat2_c4 got %b exp %b", st2(), 7'b0);
      else passes++;
   endtask

   task automatic test_back_to_back();
      logic [2:0] got;
      logic [2:0] exp;
      @(negedge clk);
      reset = 1'b0;
      bus.wr_req = 1'b1; bus.wr_addr = 17'h00010; bus.wr_data = 16'h1111;
      bus.rd_req = 1'b1; bus.rd_addr = 17'h00005;
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         got = {bus.wr_ack, bus.rd_ack, bus.rd_valid};
         if (k % 2 == 0) exp = 3'b100;
         else            exp = {2'b01, k >= 3};
         checks++;
         if (got !== exp || (bus.rd_valid && bus.rd_data !== 16'hBEEF))
            $display("FAIL alt_k%0d got %b data %h exp %b data beef", k, got, bus.rd_data, exp);
         else passes++;
      end
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_addr_err();
      rd_to_grant(17'h04000);
      checks++;
      if (st1() !== 7'b0101000) $display("FAIL rderr_grant got %b exp %b", st1(), 7'b0101000);
      else passes++;
      bus.rd_req = 1'b0;
      @(negedge clk); @(negedge clk);
      checks++;
      if (st1() !== 7'b0010000 || bus.rd_data !== 16'h0000)
         $display("FAIL rderr_ret got %b data %h exp 0010000 data 0000", st1(), bus.rd_data);
      else passes++;
      wr_to_grant(17'h1FFFF, 16'hAAAA);
      checks++;
      if (st1() !== 7'b1001000) $display("FAIL wrerr_grant got %b exp %b", st1(), 7'b1001000);
      else passes++;
      bus.wr_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_frame_done();
      wr_to_grant(17'h03FFF, 16'h7777);
      checks++;
      if (st1() !== 7'b1000111) $display("FAIL fd_last got %b exp %b", st1(), 7'b1000111);
      else passes++;
      bus.wr_req = 1'b0;
      @(negedge clk);
      checks++;
      if (st1() !== 7'b0) $display("FAIL fd_after got %b exp %b", st1(), 7'b0);
      else passes++;
      wr_to_grant(17'h03FFE, 16'h5A5A);
      checks++;
      if (st1() !== 7'b1000011) $display("FAIL fd_prev got %b exp %b", st1(), 7'b1000011);
      else passes++;
      bus.wr_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_flush();
      rd_to_grant(17'h00010);
      checks++;
      if (st1() !== 7'b0100010) $display("FAIL rst_rd_grant got %b exp %b", st1(), 7'b0100010);
      else passes++;
      bus.rd_req = 1'b0;
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      checks++;
      if (st1() !== 7'b0 || {bus.mem_addr, bus.mem_dina, bus.rd_data} !== 49'b0)
         $display("FAIL rst_async got %b bus %h exp all zero", st1(),
                  {bus.mem_addr, bus.mem_dina, bus.rd_data});
      else passes++;
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (bus.rd_valid !== 1'b0) $display("FAIL rst_no_valid_%0d got %b exp 0", k, bus.rd_valid);
         else passes++;
      end
      rd_to_grant(17'h00005);
      checks++;
      if (st1() !== 7'b0100010) $display("FAIL rst_next_grant got %b exp %b", st1(), 7'b0100010);
      else passes++;
      bus.rd_req = 1'b0;
      @(negedge clk); @(negedge clk);
      checks++;
      if (st1() !== 7'b0010000 || bus.rd_data !== 16'hBEEF)
         $display("FAIL rst_next_ret got %b data %h exp 0010000 data beef", st1(), bus.rd_data);
      else passes++;
   endtask

   initial begin
      bus.wr_req = 1'b0;  bus.wr_addr = '0;  bus.wr_data = '0;
      bus.rd_req = 1'b0;  bus.rd_addr = '0;
      bus2.wr_req = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
      bus2.rd_req = 1'b0; bus2.rd_addr = '0;
      test_reset();
      test_write_basic();
      test_read_latency();
      test_back_to_back();
      test_addr_err();
      test_frame_done();
      test_reset_flush();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
